// File: rtl/inst_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader: state encoding,
// default widths and the packed FIFO entry layout {commit, addr, data}.
package inst_memory_loader_pkg;

   localparam int unsigned INST_MEM_ENTRIES = 16;
   localparam int unsigned DEF_DATA_W       = 32;
   localparam int unsigned DEF_ADDR_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_t;

   // Reference layout at default widths; the loader declares the same
   // layout locally so it follows its own DATA_W/ADDR_W parameters.
   typedef struct packed {
      logic                  commit;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } entry_t;

   function automatic int unsigned entry_width(input int unsigned addr_w,
                                               input int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/inst_memory_loader_sync_fifo.sv
// Single-clock FIFO holding queued loader entries; pointers wrap modulo
// DEPTH and the occupancy counter distinguishes full from empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);
   assign rdata = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves level unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/inst_memory_loader.sv
// Instruction memory loader: buffers host instruction words and drains them
// into instruction memory only during the controls pipeline refresh window.
// Optional macro INST_LOADER_ATOMIC_COMMIT_EN: only committed frame updates
// are written, so a frame lands in one window or waits whole.
module inst_memory_loader
   import inst_memory_loader_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned MAX_WR = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   input  logic [ADDR_W-1:0]        cmd_addr,
   input  logic [DATA_W-1:0]        cmd_data,
   input  logic                     cmd_commit,
   output logic                     cmd_ready,
   input  logic                     refresh_window,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_waddr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy
);

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
   localparam int unsigned CNT_W = $clog2(MAX_WR + 1);
   localparam int unsigned ENT_W = entry_width(ADDR_W, DATA_W);

   typedef struct packed {
      logic              commit;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } loader_entry_t;

   loader_entry_t     in_entry;
   loader_entry_t     head;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              commit_ok;
   loader_state_t     state;
   logic [CNT_W-1:0]  wcnt;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_data;

   assign in_entry  = '{commit: cmd_commit, addr: cmd_addr, data: cmd_data};
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = mem_we;

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (in_entry),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

`ifdef INST_LOADER_ATOMIC_COMMIT_EN
   logic [LVL_W-1:0] pending;

   assign commit_ok = (pending != '0);

   // Count committed frame updates still sitting in the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         case ({push && cmd_commit, pop && head.commit})
            2'b10:   pending <= pending + 1'b1;
            2'b01:   pending <= pending - 1'b1;
            default: pending <= pending;
         endcase
      end
   end
`else
   logic unused_commit;

   assign commit_ok     = 1'b1;
   assign unused_commit = head.commit;
`endif

   // Write strobe comes straight off the FIFO head so a drain has no pipeline latency.
   assign mem_we = (state == ST_DRAIN) && refresh_window && !empty &&
                   (wcnt < CNT_W'(MAX_WR)) && commit_ok;

   // Address/data show the head while writing and otherwise hold the last written entry.
   assign mem_waddr = mem_we ? head.addr : last_addr;
   assign mem_wdata = mem_we ? head.data : last_data;
   assign busy      = (state == ST_ARM) || (state == ST_DRAIN);

   // Loader FSM with per-window write counter and last-written entry capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wcnt      <= '0;
         last_addr <= '0;
         last_data <= '0;
      end else begin
         if (mem_we) begin
            last_addr <= head.addr;
            last_data <= head.data;
         end
         case (state)
            ST_IDLE: begin
               if (refresh_window) begin
                  state <= ST_ARM;
                  wcnt  <= '0;
               end
            end
            ST_ARM: begin
               state <= refresh_window ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
               if (!refresh_window) begin
                  state <= ST_IDLE;
               end else if (mem_we) begin
                  wcnt <= wcnt + 1'b1;
                  // Empty after this pop unless a push refills it in the same edge.
                  if (((fifo_level == LVL_W'(1)) && !push) ||
                      (wcnt == CNT_W'(MAX_WR - 1)))
                     state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!refresh_window) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_memory_loader.sv
// Directed self-checking bench for inst_memory_loader: one default instance
// and one with MAX_WR=4 to exercise the per-window write budget.
module tb_inst_memory_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_commit, cmd_ready, refresh_window, mem_we, busy;
   logic [3:0]  cmd_addr, mem_waddr, fifo_level;
   logic [31:0] cmd_data, mem_wdata;

   logic        cmd_valid4, cmd_commit4, cmd_ready4, refresh_window4, mem_we4, busy4;
   logic [3:0]  cmd_addr4, mem_waddr4, fifo_level4;
   logic [31:0] cmd_data4, mem_wdata4;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   inst_memory_loader #(.DATA_W(32), .ADDR_W(4), .DEPTH(8), .MAX_WR(16)) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_commit(cmd_commit), .cmd_ready(cmd_ready),
      .refresh_window(refresh_window), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .fifo_level(fifo_level), .busy(busy)
   );

   inst_memory_loader #(.DATA_W(32), .ADDR_W(4), .DEPTH(8), .MAX_WR(4)) u_dut4 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid4), .cmd_addr(cmd_addr4),
      .cmd_data(cmd_data4), .cmd_commit(cmd_commit4), .cmd_ready(cmd_ready4),
      .refresh_window(refresh_window4), .mem_we(mem_we4), .mem_waddr(mem_waddr4),
      .mem_wdata(mem_wdata4), .fifo_level(fifo_level4), .busy(busy4)
   );

   // Advance past the next rising edge; inputs are then driven mid-cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic [3:0] a, input logic [31:0] d, input logic c);
      cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_commit = c;
      tick();
      cmd_valid = 1'b0; cmd_commit = 1'b0;
   endtask

   task automatic push_word4(input logic [3:0] a, input logic [31:0] d);
      cmd_valid4 = 1'b1; cmd_addr4 = a; cmd_data4 = d;
      tick();
      cmd_valid4 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cmd_valid = 0; cmd_addr = '0; cmd_data = '0; cmd_commit = 0; refresh_window = 0;
      cmd_valid4 = 0; cmd_addr4 = '0; cmd_data4 = '0; cmd_commit4 = 0; refresh_window4 = 0;
      #12;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", mem_we); end
      n_checks++; if (mem_waddr !== 4'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", mem_waddr); end
      n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic_drain();
      logic [3:0]  ea [3] = '{4'd2, 4'd5, 4'd9};
      logic [31:0] ed [3] = '{32'hA, 32'hB, 32'hC};
      for (int i = 0; i < 3; i++) push_word(ea[i], ed[i], 1'b0);
      #1;
      n_checks++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL basic_level3 got=%0d exp=3", fifo_level); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL basic_nowin_we got=%b exp=0", mem_we); end
      refresh_window = 1'b1;
      #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL basic_idle_we got=%b exp=0", mem_we); end
      tick(); #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL basic_arm_we got=%b exp=0", mem_we); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_arm_busy got=%b exp=1", busy); end
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL basic_we[%0d] got=%b exp=1", i, mem_we); end
         n_checks++; if (mem_waddr !== ea[i]) begin n_fail++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, mem_waddr, ea[i]); end
         n_checks++; if (mem_wdata !== ed[i]) begin n_fail++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, mem_wdata, ed[i]); end
      end
      tick(); #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL basic_done_we got=%b exp=0", mem_we); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL basic_done_level got=%0d exp=0", fifo_level); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_busy got=%b exp=0", busy); end
      n_checks++; if (mem_waddr !== 4'd9) begin n_fail++; $display("FAIL basic_hold_addr got=%0d exp=9", mem_waddr); end
      refresh_window = 1'b0;
      tick();
   endtask

   task automatic test_full_backpressure();
      logic [3:0] rest [6] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15};
      for (int i = 0; i < 8; i++) push_word(4'(i), 32'h100 + i, 1'b0);
      #1;
      n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", cmd_ready); end
      cmd_valid = 1'b1; cmd_addr = 4'd15; cmd_data = 32'h1FF;
      tick(); #1;
      n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_held got=%0d exp=8", fifo_level); end
      refresh_window = 1'b1;
      tick(); tick(); #1;
      n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'd0) begin n_fail++; $display("FAIL full_first_pop got=%b/%0d exp=1/0", mem_we, mem_waddr); end
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got=%b exp=0", cmd_ready); end
      tick(); #1;
      n_checks++; if (fifo_level !== 4'd7) begin n_fail++; $display("FAIL full_after_pop got=%0d exp=7", fifo_level); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got=%b exp=1", cmd_ready); end
      n_checks++; if (mem_waddr !== 4'd1) begin n_fail++; $display("FAIL full_addr1 got=%0d exp=1", mem_waddr); end
      tick();
      cmd_valid = 1'b0;
      #1;
      n_checks++; if (fifo_level !== 4'd7) begin n_fail++; $display("FAIL full_push_pop got=%0d exp=7", fifo_level); end
      n_checks++; if (mem_waddr !== 4'd2) begin n_fail++; $display("FAIL full_addr2 got=%0d exp=2", mem_waddr); end
      for (int i = 0; i < 6; i++) begin
         tick(); #1;
         n_checks++; if (mem_we !== 1'b1 || mem_waddr !== rest[i]) begin n_fail++; $display("FAIL full_seq[%0d] got=%b/%0d exp=1/%0d", i, mem_we, mem_waddr, rest[i]); end
      end
      n_checks++; if (mem_wdata !== 32'h1FF) begin n_fail++; $display("FAIL full_held_data got=%h exp=1ff", mem_wdata); end
      tick(); #1;
      n_checks++; if (mem_we !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL full_done got=%b/%0d exp=0/0", mem_we, fifo_level); end
      refresh_window = 1'b0;
      tick();
   endtask

   task automatic test_window_drop();
      for (int i = 0; i < 5; i++) push_word(4'(3 + i), 32'h50 + i, 1'b0);
      refresh_window = 1'b1;
      tick(); tick(); #1;
      n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'd3) begin n_fail++; $display("FAIL drop_w0 got=%b/%0d exp=1/3", mem_we, mem_waddr); end
      tick(); #1;
      n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'd4) begin n_fail++; $display("FAIL drop_w1 got=%b/%0d exp=1/4", mem_we, mem_waddr); end
      tick();
      refresh_window = 1'b0;
      #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL drop_we got=%b exp=0", mem_we); end
      n_checks++; if (mem_waddr !== 4'd4 || mem_wdata !== 32'h51) begin n_fail++; $display("FAIL drop_hold got=%0d/%h exp=4/51", mem_waddr, mem_wdata); end
      n_checks++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL drop_level got=%0d exp=3", fifo_level); end
      tick(); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
      refresh_window = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'(5 + i) || mem_wdata !== 32'h52 + i) begin
            n_fail++; $display("FAIL drop_resume[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, mem_we, mem_waddr, mem_wdata, 5 + i, 32'h52 + i); end
      end
      tick(); #1;
      n_checks++; if (mem_we !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL drop_done got=%b/%0d exp=0/0", mem_we, fifo_level); end
      refresh_window = 1'b0;
      tick();
   endtask

   task automatic test_max_wr();
      for (int i = 0; i < 6; i++) push_word4(4'(8 + i), 32'h80 + i);
      refresh_window4 = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         n_checks++; if (mem_we4 !== 1'b1 || mem_waddr4 !== 4'(8 + i)) begin n_fail++; $display("FAIL maxwr_w[%0d] got=%b/%0d exp=1/%0d", i, mem_we4, mem_waddr4, 8 + i); end
      end
      tick(); #1;
      n_checks++; if (mem_we4 !== 1'b0) begin n_fail++; $display("FAIL maxwr_stop got=%b exp=0", mem_we4); end
      n_checks++; if (fifo_level4 !== 4'd2) begin n_fail++; $display("FAIL maxwr_level got=%0d exp=2", fifo_level4); end
      n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL maxwr_done_busy got=%b exp=0", busy4); end
      refresh_window4 = 1'b0;
      tick();
      refresh_window4 = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         tick(); #1;
         n_checks++; if (mem_we4 !== 1'b1 || mem_waddr4 !== 4'(12 + i)) begin n_fail++; $display("FAIL maxwr_next[%0d] got=%b/%0d exp=1/%0d", i, mem_we4, mem_waddr4, 12 + i); end
      end
      tick(); #1;
      n_checks++; if (mem_we4 !== 1'b0 || fifo_level4 !== 4'd0) begin n_fail++; $display("FAIL maxwr_empty got=%b/%0d exp=0/0", mem_we4, fifo_level4); end
      refresh_window4 = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 4; i++) push_word(4'(i), 32'hD0 + i, 1'b0);
      refresh_window = 1'b1;
      tick(); tick(); #1;
      n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we got=%b exp=1", mem_we); end
      reset = 1'b0; refresh_window = 1'b0;
      #1;
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b exp=0", mem_we); end
      n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
      n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_ready_busy got=%b/%b exp=1/0", cmd_ready, busy); end
      tick();
      reset = 1'b1;
      tick();
      refresh_window = 1'b1;
      tick(); tick(); #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_drain_busy got=%b exp=1", busy); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_nowrite[%0d] got=%b exp=0", i, mem_we); end
         tick(); #1;
      end
      refresh_window = 1'b0;
      tick();
   endtask

`ifdef INST_LOADER_ATOMIC_COMMIT_EN
   task automatic test_atomic_commit();
      push_word(4'd1, 32'h61, 1'b0);
      push_word(4'd2, 32'h62, 1'b1);
      push_word(4'd3, 32'h63, 1'b0);
      push_word(4'd4, 32'h64, 1'b0);
      refresh_window = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         tick(); #1;
         n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'(1 + i)) begin n_fail++; $display("FAIL atomic_w[%0d] got=%b/%0d exp=1/%0d", i, mem_we, mem_waddr, 1 + i); end
      end
      tick(); #1;
      n_checks++; if (mem_we !== 1'b0 || fifo_level !== 4'd2) begin n_fail++; $display("FAIL atomic_hold got=%b/%0d exp=0/2", mem_we, fifo_level); end
      refresh_window = 1'b0;
      tick();
      push_word(4'd5, 32'h65, 1'b1);
      refresh_window = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 4'(3 + i)) begin n_fail++; $display("FAIL atomic_next[%0d] got=%b/%0d exp=1/%0d", i, mem_we, mem_waddr, 3 + i); end
      end
      tick(); #1;
      n_checks++; if (mem_we !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL atomic_done got=%b/%0d exp=0/0", mem_we, fifo_level); end
      refresh_window = 1'b0;
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_drain();
      test_full_backpressure();
      test_window_drop();
      test_max_wr();
      test_reset_mid_drain();
`ifdef INST_LOADER_ATOMIC_COMMIT_EN
      test_atomic_commit();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
